mul_div_unit: RTL
=================

// Module: mul_div_unit
// PURPOSE
//  Iterative MIPS multiply/divide unit with architectural HI/LO registers. Sits directly
//  downstream of the register file: consumes read_reg1 (rs) / read_reg2 (rt) and executes
//  MULT/MULTU/DIV/DIVU over a fixed 33-cycle latency. Exposes busy so the pipeline can stall
//  MFHI/MFLO/mul-div issue. Also accepts MTHI/MTLO writes.
// PARAMETERS
//  XLEN   32  operand width; HI/LO are XLEN each (only 32 is verified)
//  CNT_W  5   iteration counter width, $clog2(XLEN)
// PORTS
//  CLK      in   1     clock, all state updates on rising edge
//  reset    in   1     asynchronous, active-low; clears all state
//  start    in   1     issue request, sampled only when busy==0
//  op       in   2     00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//  rs_data  in   XLEN  operand A / dividend (register file read port 1)
//  rt_data  in   XLEN  operand B / divisor  (register file read port 2)
//  hi_we    in   1     MTHI write enable
//  lo_we    in   1     MTLO write enable
//  mt_data  in   XLEN  MTHI/MTLO data
//  flush    in   1     abort in-flight operation
//  busy     out  1     operation in flight
//  done     out  1     one-cycle pulse: HI/LO just updated by a mul/div
//  hi       out  XLEN  HI register
//  lo       out  XLEN  LO register
// BEHAVIOUR
//  - Reset (reset==0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
//  - FSM: IDLE -> CALC -> FIX -> IDLE; all outputs registered.
//  - IDLE: start==1 at edge E0 -> latch |A|,|B| (signed ops) or raw (unsigned ops), record
//    result signs, counter=0, state=CALC, busy=1 from E0.
//  - CALC: one radix-2 step per edge, E1..E32; counter increments, CALC->FIX at E32.
//    Multiply: shift-add into 2*XLEN accumulator. Divide: restoring, 1 quotient bit/step.
//  - FIX (edge E33): apply signs, load hi/lo, busy=0, done=1 for the cycle after E33 only.
//    Mul: {hi,lo}=64-bit product, negated if op==MULT and signs differ.
//    Div: lo=quotient, hi=remainder; signed quotient negated if signs differ; signed
//    remainder takes dividend sign. 0x80000000/-1 (DIV) -> lo=0x80000000, hi=0.
//  - Divide by zero (rt_data==0 at E0, DIV or DIVU): still full latency; result
//    lo=0xFFFFFFFF, hi=rs_data as latched at E0.
//  - start while busy==1: ignored, no queueing.
//  - MTHI/MTLO: when busy==0, hi_we/lo_we load mt_data at next edge; both may fire together.
//    While busy==1 they are ignored. start and hi_we/lo_we in same IDLE cycle: start wins,
//    writes dropped.
//  - flush: synchronous; any state -> IDLE next edge, busy=0, done=0, hi/lo unchanged.
//    flush in FIX cycle suppresses the HI/LO update. flush and start together in IDLE: no issue.
//  - Reset asserted mid-operation: immediate clear per reset values; no done pulse.
//  - hi/lo stable between updates; operands need only be valid in the start cycle.
// TESTING
//  1. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> after 33 edges hi=0xFFFFFFFE, lo=0x00000001, done 1 cycle.
//  2. MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
//  3. DIV -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2.
//  4. DIVU 5/0 -> lo=0xFFFFFFFF, hi=5; DIV 0x80000000/-1 -> lo=0x80000000, hi=0.
//  5. start during busy and hi_we during busy -> ignored; hi_we+lo_we in IDLE with
//     mt_data=0x1234 -> hi=lo=0x1234 next edge; start+hi_we same cycle -> hi from mul only.
//  6. flush at CALC cycle 10 -> busy=0 next edge, hi/lo unchanged, no done; reset=0 at
//     cycle 20 -> hi=lo=0, busy=0 immediately.

Source files
------------

// File: rtl/mul_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply or restoring divide on
// magnitudes, then a single fix-up cycle applies signs and loads HI/LO.
// Fixed latency: busy for 33 cycles, done pulses once when HI/LO update.
module mul_div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs_data,
    input  logic [XLEN-1:0] rt_data,
    input  logic            hi_we,
    input  logic            lo_we,
    input  logic [XLEN-1:0] mt_data,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t              r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_is_div;
    logic                r_div_zero;
    logic                r_neg_res;   // negate product / quotient
    logic                r_neg_rem;   // remainder follows dividend sign
    logic [XLEN-1:0]     r_opb;       // multiplicand or divisor magnitude
    logic [2*XLEN-1:0]   r_acc;       // {upper, lower} working register
    logic [XLEN-1:0]     r_hi;
    logic [XLEN-1:0]     r_lo;
    logic                r_busy;
    logic                r_done;

    // Operand decode at issue: op[0]=0 is signed, op[1]=1 is divide
    logic                w_signed;
    logic                w_a_neg;
    logic                w_b_neg;
    logic [XLEN-1:0]     w_abs_a;
    logic [XLEN-1:0]     w_abs_b;

    assign w_signed = ~op[0];
    assign w_a_neg  = w_signed & rs_data[XLEN-1];
    assign w_b_neg  = w_signed & rt_data[XLEN-1];
    assign w_abs_a  = w_a_neg ? -rs_data : rs_data;
    assign w_abs_b  = w_b_neg ? -rt_data : rt_data;

    // Multiply step: lower half holds the remaining multiplier bits; add the
    // multiplicand into the upper half when the current bit is set, shift right.
    logic [XLEN:0]       w_mul_sum;
    logic [2*XLEN-1:0]   w_mul_next;

    assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                        (r_acc[0] ? {1'b0, r_opb} : {(XLEN+1){1'b0}});
    assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

    // Divide step: shift {rem, dividend} left one; if the shifted remainder
    // covers the divisor, subtract and shift in a 1 quotient bit.
    // A zero divisor always "fits", giving all-ones quotient and rem=|A|.
    logic [XLEN:0]       w_rem_sh;
    logic [XLEN:0]       w_diff;
    logic                w_fits;
    logic [2*XLEN-1:0]   w_div_next;

    assign w_rem_sh   = r_acc[2*XLEN-1:XLEN-1];
    assign w_diff     = w_rem_sh - {1'b0, r_opb};
    assign w_fits     = (w_rem_sh >= {1'b0, r_opb});
    assign w_div_next = w_fits ? {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1}
                               : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

    // Sign fix-up for the final write
    logic [2*XLEN-1:0]   w_prod_fix;
    logic [XLEN-1:0]     w_quo;
    logic [XLEN-1:0]     w_rem;
    logic [XLEN-1:0]     w_quo_fix;
    logic [XLEN-1:0]     w_rem_fix;

    assign w_prod_fix = r_neg_res ? -r_acc : r_acc;
    assign w_quo      = r_acc[XLEN-1:0];
    assign w_rem      = r_acc[2*XLEN-1:XLEN];
    assign w_quo_fix  = r_div_zero ? {XLEN{1'b1}} : (r_neg_res ? -w_quo : w_quo);
    assign w_rem_fix  = r_neg_rem ? -w_rem : w_rem;

    // Control FSM, datapath iteration and HI/LO architectural state
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_is_div   <= 1'b0;
            r_div_zero <= 1'b0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_opb      <= '0;
            r_acc      <= '0;
            r_hi       <= '0;
            r_lo       <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush) begin
                        r_busy <= 1'b0;
                    end else if (start) begin
                        // issue wins over any simultaneous MTHI/MTLO
                        r_state    <= S_CALC;
                        r_busy     <= 1'b1;
                        r_cnt      <= '0;
                        r_is_div   <= op[1];
                        r_div_zero <= op[1] & (rt_data == '0);
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= op[1] & w_a_neg;
                        r_opb      <= w_abs_b;
                        r_acc      <= {{XLEN{1'b0}}, w_abs_a};
                    end else begin
                        if (hi_we) r_hi <= mt_data;
                        if (lo_we) r_lo <= mt_data;
                    end
                end
                S_CALC: begin
                    if (flush) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                    end else begin
                        r_acc <= r_is_div ? w_div_next : w_mul_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(XLEN-1))
                            r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    if (!flush) begin
                        r_done <= 1'b1;
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quo_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*XLEN-1:XLEN];
                            r_lo <= w_prod_fix[XLEN-1:0];
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
